// File: rtl/tpu_isa_pkg.sv
// Shared ISA definitions: instruction field widths, the packed instruction
// layout used by the buffer and the decoder, and small sizing helpers.
package tpu_isa_pkg;

    localparam int unsigned OPCODE_W     = 8;
    localparam int unsigned FLAG_W       = 8;
    localparam int unsigned LENGTH_W     = 8;
    localparam int unsigned HOST_ADDR_W  = 64;
    localparam int unsigned LOCAL_ADDR_W = 24;
    localparam int unsigned INSTR_W      = OPCODE_W + FLAG_W + LENGTH_W + HOST_ADDR_W + LOCAL_ADDR_W;
    localparam int unsigned HOST_WORD_W  = 32;
    localparam int unsigned IBUF_DEPTH   = 8;

    // MSB-first field order; the decoder slices instructions with this layout
    typedef struct packed {
        logic [OPCODE_W-1:0]     opcode;
        logic [FLAG_W-1:0]       flags;
        logic [LENGTH_W-1:0]     length;
        logic [HOST_ADDR_W-1:0]  host_addr;
        logic [LOCAL_ADDR_W-1:0] local_addr;
    } instr_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head entry,
// valid flag, occupancy and full flag; flush clears it in one cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 112,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] head_q, head_d;

    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    rd_next;

    assign do_push = push_i & ~flush_i & ~full_q;
    assign do_pop  = pop_i & ~flush_i & valid_q;
    assign rd_next = rd_ptr_q + AW'(1);

    // Next-state: pointers, occupancy and the head copy that feeds data_o
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_next;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
            // A popped head is replaced by the next stored entry, or by the
            // word arriving this cycle when the FIFO held only the old head.
            if (do_pop) begin
                if (count_q > CW'(1)) begin
                    head_d = mem[rd_next];
                end else if (do_push) begin
                    head_d = push_data_i;
                end
            end else if (do_push && (count_q == '0)) begin
                head_d = push_data_i;
            end
        end
        valid_d = (count_d != '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            head_q   <= head_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = head_q;
    assign count_o = count_q;
    assign full_o  = full_q;

endmodule

// File: rtl/instruction_buffer.sv
// Assembles host words into full instructions (little-endian by beat) and
// queues them for the instruction decoder behind a valid/ready handshake.
module instruction_buffer
    import tpu_isa_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH               = OPCODE_W,
    parameter int unsigned FLAG_WIDTH                 = FLAG_W,
    parameter int unsigned LENGTH_WIDTH               = LENGTH_W,
    parameter int unsigned HOST_MEMORY_ADDRESS_WIDTH  = HOST_ADDR_W,
    parameter int unsigned LOCAL_MEMORY_ADDRESS_WIDTH = LOCAL_ADDR_W,
    parameter int unsigned HOST_WORD_WIDTH            = HOST_WORD_W,
    parameter int unsigned DEPTH                      = IBUF_DEPTH,
    localparam int unsigned INSTRUCTION_WIDTH = OPCODE_WIDTH + FLAG_WIDTH + LENGTH_WIDTH
                                              + HOST_MEMORY_ADDRESS_WIDTH + LOCAL_MEMORY_ADDRESS_WIDTH,
    localparam int unsigned BEATS  = ceil_div(INSTRUCTION_WIDTH, HOST_WORD_WIDTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1,
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [HOST_WORD_WIDTH-1:0]   in_word,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
    output logic [CNT_W-1:0]             count,
    output logic [BEAT_W-1:0]            beat_idx,
    output logic                         overflow_err
);

    localparam int unsigned PART_W = (BEATS - 1) * HOST_WORD_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [BEAT_W-1:0]            beat_q, beat_d;
    logic [PART_W-1:0]            part_q, part_d;
    logic                         ovf_q, ovf_d;

    logic                         last_beat;
    logic                         fifo_full;
    logic                         accept;
    logic                         push;
    logic                         pop;
    logic [INSTRUCTION_WIDTH-1:0] push_data;

    // Only a final beat needs FIFO space; flush keeps the host side open
    assign last_beat = (beat_q == LAST_BEAT);
    assign in_ready  = flush | ~last_beat | ~fifo_full;
    assign accept    = in_valid & in_ready & ~flush;
    assign push      = accept & last_beat;
    assign pop       = out_valid & out_ready;

    // Final word sits on top of the stored words; bits past the instruction drop
    assign push_data = INSTRUCTION_WIDTH'({in_word, part_q});

    always_comb begin
        beat_d = beat_q;
        part_d = part_q;
        ovf_d  = ovf_q | (in_valid & last_beat & fifo_full & ~flush);
        if (flush) begin
            beat_d = '0;
            part_d = '0;
        end else if (accept) begin
            if (last_beat) begin
                beat_d = '0;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
                for (int k = 0; k < int'(BEATS) - 1; k++) begin
                    if (beat_q == BEAT_W'(k)) begin
                        part_d[k*HOST_WORD_WIDTH +: HOST_WORD_WIDTH] = in_word;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            part_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            beat_q <= beat_d;
            part_q <= part_d;
            ovf_q  <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (INSTRUCTION_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .valid_o     (out_valid),
        .data_o      (out_instruction),
        .count_o     (count),
        .full_o      (fifo_full)
    );

    assign beat_idx     = beat_q;
    assign overflow_err = ovf_q;

endmodule

// File: doc/instruction_buffer.md
Name: instruction_buffer

Overview:
- Upstream neighbour of instruction_decoder.
- Accepts host instruction stream as fixed-width host words and assembles each group of words into one full instruction (OPCODE|FLAG|LENGTH|HOST_ADDR|LOCAL_ADDR, 112 bits at defaults).
- Queues assembled instructions in a small FIFO and presents them to the decoder over a valid/ready handshake.
- Decouples host transfer bursts from decoder/issue stalls.

Parameters:
- OPCODE_WIDTH, 8, opcode field width
- FLAG_WIDTH, 8, flag field width
- LENGTH_WIDTH, 8, length field width
- HOST_MEMORY_ADDRESS_WIDTH, 64, host address field width
- LOCAL_MEMORY_ADDRESS_WIDTH, 24, local address field width
- INSTRUCTION_WIDTH, sum of the five above (112), full instruction width
- HOST_WORD_WIDTH, 32, width of one inbound host word
- BEATS, ceil(INSTRUCTION_WIDTH/HOST_WORD_WIDTH) (4), words per instruction; derived, never overridden
- DEPTH, 8, FIFO entries; power of two, >= 2

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- flush  input  1  synchronous clear of FIFO and partial assembly
- in_valid  input  1  host word valid
- in_ready  output  1  host word accepted when in_valid & in_ready
- in_word  input  HOST_WORD_WIDTH  host word
- out_valid  output  1  instruction available to decoder
- out_ready  input  1  decoder consumes when out_valid & out_ready
- out_instruction  output  INSTRUCTION_WIDTH  head-of-queue instruction
- count  output  clog2(DEPTH)+1  FIFO occupancy
- beat_idx  output  clog2(BEATS)  index of next expected word
- overflow_err  output  1  sticky: in_valid while in_ready low on a final beat

Behaviour:
- Reset: in_ready=1, out_valid=0, out_instruction=0, count=0, beat_idx=0, overflow_err=0. FIFO pointers cleared. Partial-assembly register cleared. Asserting rst mid-instruction discards all partial words.
- Assembly order: word k fills bits [k*HOST_WORD_WIDTH +: HOST_WORD_WIDTH], little-endian by beat. On the final beat, bits above INSTRUCTION_WIDTH-1 (upper 16 at defaults) are ignored.
- beat_idx increments on each accepted word and wraps BEATS-1 -> 0.
- An accepted word at beat_idx=BEATS-1 pushes {word, partial} into the FIFO in the same clock edge.
- in_ready = (beat_idx != BEATS-1) | (count < DEPTH). Non-final beats are always accepted. in_ready has no combinational dependence on out_ready: a pop in the same cycle does not free space for a final beat.
- FIFO is first-word fall-through with registered outputs. A final beat accepted at edge N gives out_valid=1 with that instruction after edge N (visible in cycle N+1). Latency is 1 cycle when the FIFO was empty.
- out_instruction holds stable while out_valid & !out_ready.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. Never exceeds DEPTH, never underflows. A pop with count=0 is impossible because out_valid=0.
- Pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
- overflow_err sets when in_valid=1, beat_idx=BEATS-1 and count==DEPTH. The word is not accepted. Cleared only by rst, not by flush.
- flush (synchronous, highest priority after rst): count=0, beat_idx=0, out_valid=0, pointers cleared. Any push or pop in that cycle is discarded. in_ready stays 1 during flush.
- Conflicting events: rst beats flush, flush beats push/pop, push+pop at count=DEPTH cannot occur.

Decomposition:
- Shared package (tpu_isa_pkg):
  - field width constants and INSTRUCTION_WIDTH
  - packed struct instr_t {opcode, flags, length, host_addr, local_addr}, MSB-first in that order, matching the decoder's slicing
- One sub-module: sync_fifo (WIDTH, DEPTH; push/pop/flush, count, FWFT registered data). Reused later for the result path.
- Assembler and beat counter stay in instruction_buffer.

Test Plan:
- Single instruction: words 0x11223344, 0x55667788, 0x99AABBCC, 0xDEADBEEF, out_ready=1 -> one cycle after last beat, out_valid=1 and out_instruction=0xBEEF_99AABBCC_55667788_11223344; count returns 0 after pop.
- Fill: out_ready=0, stream 8 instructions -> count=8, in_ready drops only at beat_idx=3. A 9th final beat sets overflow_err=1, count stays 8 and the word is not taken.
- Simultaneous push/pop at count=4 -> count stays 4, FIFO order preserved across the pointer wrap (push 20 instructions with random out_ready, compare against a scoreboard).
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_instruction stable. Releasing out_ready pops exactly one entry per cycle.
- Flush mid-instruction after 2 words with 3 queued -> next cycle count=0, beat_idx=0, out_valid=0. The next 4 words form a fresh instruction. overflow_err is unchanged.
- Async rst pulse between clock edges mid-beat -> outputs reach reset values immediately, without waiting for a clock edge. After release, the first 4 words assemble correctly.
